dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported L1 data memory between the scalar pipeline's MEM stage and the vector unit's load/store port. It accepts single-beat scalar requests and locked multi-beat vector bursts. Each accepted beat is issued to the memory as one registered command, and the synchronous read data (or a fault) is routed back to the requester that owns it. The block sits between the EX/MEM boundary and the data RAM, so every data-memory access goes through it.

## Interface
- MEM_WORDS, 512: depth of the data RAM in 64-bit words; index width IW = $clog2(MEM_WORDS)
- MAX_BURST, 8: maximum beats a vector burst may hold the grant
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous assert, active-high
- s_req_valid / s_req_ready  in / out  1  scalar request handshake
- s_req_we  in  1  scalar write (1) or read (0)
- s_req_addr  in  64  scalar byte address
- s_req_wdata  in  64  scalar write data
- s_rsp_valid  out  1  scalar response strobe, one per accepted beat
- s_rsp_rdata  out  64  read data; 0 for writes and faults
- s_rsp_fault  out  1  access fault for this beat
- v_req_valid / v_req_ready / v_req_we / v_req_addr / v_req_wdata  same as scalar, vector port
- v_req_last  in  1  final beat of the vector burst
- v_rsp_valid / v_rsp_rdata / v_rsp_fault  out  1/64/1  vector response, same semantics
- m_en  out  1  RAM command strobe
- m_we  out  1  RAM write enable
- m_addr  out  IW  RAM word index (byte address >> 3)
- m_wdata  out  64  RAM write data
- m_rdata  in  64  RAM read data, valid the cycle after m_en & !m_we
- busy  out  1  state != IDLE or any beat in flight

## Operation
- FSM states: IDLE, SCAL, VEC.
- IDLE:
  - Only s_req_valid → SCAL. Only v_req_valid → VEC.
  - Both valid → winner per Configuration.
  - Neither valid → stay in IDLE.
- SCAL:
  - s_req_ready = 1.
  - On handshake → IDLE.
  - If s_req_valid drops while in SCAL, stay in SCAL.
- VEC:
  - v_req_ready = 1. Beat counter starts at 0 on entry and increments per handshake.
  - → IDLE on a handshake with v_req_last = 1, or on the handshake that brings the count to MAX_BURST (forced release, no error).
- Ready outputs are decoded from the registered state only; no combinational valid→ready path.
- Fault check per accepted beat: fault if addr[2:0] != 0, or if addr >> 3 >= MEM_WORDS.
  - A faulting beat suppresses m_en.
  - A faulting beat still produces a response with fault = 1 and rdata = 0.
- Each accepted beat enters a 2-stage tag pipeline: valid, owner, we, fault.
  - Stage 1 drives m_en/m_we/m_addr/m_wdata.
  - Stage 2 drives the owner's rsp_valid.
  - rsp_rdata = m_rdata for non-faulting reads, else 0.
- The non-owner's rsp_valid is 0.
- m_addr uses address bits [IW+2:3]; upper bits serve only the range check.

## Timing
- Reset values:
  - state = IDLE, both ready = 0.
  - m_en = m_we = 0, m_addr = 0, m_wdata = 0.
  - both rsp_valid = 0, rdata = 0, fault = 0.
  - busy = 0.
  - Round-robin pointer points at scalar.
- Arbitration: valid seen in IDLE at edge k → ready high during cycle k+1.
- Latency:
  - Handshake in cycle N → m_en in cycle N+1.
  - rsp_valid in cycle N+2, for reads and writes alike.
- Throughput: scalar 1 beat per 2 cycles; vector 1 beat per cycle inside a burst.
- Simultaneous events: scalar valid during a vector burst waits; it is granted on the first arbitration after release.
- Write followed by read of the same address in a burst: the read returns the new data, because RAM is write-first by command order.
- Reset mid-operation: all in-flight beats are dropped with no response emitted, and the FSM returns to IDLE immediately.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin on contention.
  - The port not granted most recently wins.
  - The pointer updates on each grant out of IDLE.
- DMEM_ARB_RR_EN undefined: fixed priority on contention; scalar always wins. A continuous scalar stream may starve the vector port; this is accepted for a scalar-only build.

## Structure
- Package dmem_arb_pkg holds:
  - state enum {IDLE, SCAL, VEC}
  - owner encoding OWN_S = 0, OWN_V = 1
  - the beat tag struct {valid, owner, we, fault}
  - defaults for MEM_WORDS and MAX_BURST
- One sub-module, dmem_arb_fault_chk: combinational alignment/range check, reused per port.

## Test plan
- Scalar read of addr 0x40 with RAM word 8 = 0xDEAD_BEEF: m_en at N+1 with m_addr = 8; s_rsp_valid at N+2 with rdata 0xDEAD_BEEF and fault 0.
- Vector 4-beat write burst to 0x100..0x118, then a 4-beat read of the same range: 4 consecutive m_en cycles per burst; read responses return the written data in order; IDLE after the last beat.
- Both ports valid every cycle:
  - With DMEM_ARB_RR_EN, grants alternate S, V, S, V.
  - Without it, scalar is granted every time and v_req_ready stays 0.
- Vector burst of 10 beats with v_req_last never set (MAX_BURST = 8): grant released after beat 8; a pending scalar request is served next.
- Scalar read at 0x1003 (misaligned) and at 0x1000 (word 512, out of range): no m_en; s_rsp_fault = 1 with rdata 0 at N+2.
- Assert rst in the cycle after a vector handshake: no v_rsp_valid is emitted, all outputs return to reset values, and the next request behaves normally.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared states, owner encoding, beat tag and defaults for dmem_arbiter
package dmem_arb_pkg;

  localparam int DEF_MEM_WORDS = 512;
  localparam int DEF_MAX_BURST = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAL = 2'd1,
    VEC  = 2'd2
  } arb_state_t;

  localparam logic OWN_S = 1'b0;
  localparam logic OWN_V = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic we;
    logic fault;
  } beat_tag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - scalar/vector request-response ports and RAM command bus
interface dmem_arbiter_if #(
  parameter int IW = 9
);

  logic          s_req_valid;
  logic          s_req_ready;
  logic          s_req_we;
  logic [63:0]   s_req_addr;
  logic [63:0]   s_req_wdata;
  logic          s_rsp_valid;
  logic [63:0]   s_rsp_rdata;
  logic          s_rsp_fault;

  logic          v_req_valid;
  logic          v_req_ready;
  logic          v_req_we;
  logic [63:0]   v_req_addr;
  logic [63:0]   v_req_wdata;
  logic          v_req_last;
  logic          v_rsp_valid;
  logic [63:0]   v_rsp_rdata;
  logic          v_rsp_fault;

  logic          m_en;
  logic          m_we;
  logic [IW-1:0] m_addr;
  logic [63:0]   m_wdata;
  logic [63:0]   m_rdata;

  modport master (
    output s_req_valid, s_req_we, s_req_addr, s_req_wdata,
    input  s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_fault,
    output v_req_valid, v_req_we, v_req_addr, v_req_wdata, v_req_last,
    input  v_req_ready, v_rsp_valid, v_rsp_rdata, v_rsp_fault,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );

  modport slave (
    input  s_req_valid, s_req_we, s_req_addr, s_req_wdata,
    output s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_fault,
    input  v_req_valid, v_req_we, v_req_addr, v_req_wdata, v_req_last,
    output v_req_ready, v_rsp_valid, v_rsp_rdata, v_rsp_fault,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

endinterface

// File: rtl/dmem_arb_fault_chk.sv
// rtl/dmem_arb_fault_chk.sv - alignment and range check for one request address
module dmem_arb_fault_chk
  import dmem_arb_pkg::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic [63:0] addr,
  output logic        fault
);

  logic misaligned;
  logic out_of_range;

  // The full upper address takes part so aliases above the RAM are rejected.
  always_comb begin
    misaligned   = |addr[2:0];
    out_of_range = (addr[63:3] >= 61'(MEM_WORDS));
    fault        = misaligned | out_of_range;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the L1 data RAM between scalar MEM stage and vector port
// DMEM_ARB_RR_EN selects round-robin on contention; otherwise scalar has fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic          busy
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state;
  arb_state_t    state_nx;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_cnt_nx;

  logic          s_fault;
  logic          v_fault;
  logic          s_hs;
  logic          v_hs;
  logic          grant_s;
  logic          grant_v;

  beat_tag_t     tag_in;
  beat_tag_t     tag1;
  beat_tag_t     tag2;
  logic [63:0]   sel_addr;
  logic [63:0]   sel_wdata;
  logic [63:0]   rsp_data;

  dmem_arb_fault_chk #(.MEM_WORDS(MEM_WORDS)) u_s_chk (
    .addr  (bus.s_req_addr),
    .fault (s_fault)
  );

  dmem_arb_fault_chk #(.MEM_WORDS(MEM_WORDS)) u_v_chk (
    .addr  (bus.v_req_addr),
    .fault (v_fault)
  );

  assign bus.s_req_ready = (state == SCAL);
  assign bus.v_req_ready = (state == VEC);
  assign s_hs            = bus.s_req_valid & bus.s_req_ready;
  assign v_hs            = bus.v_req_valid & bus.v_req_ready;

`ifdef DMEM_ARB_RR_EN
  logic rr_prio;

  // rr_prio names the port that wins the next contended IDLE decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_prio <= OWN_S;
    end else if (state == IDLE && grant_s) begin
      rr_prio <= OWN_V;
    end else if (state == IDLE && grant_v) begin
      rr_prio <= OWN_S;
    end
  end
`endif

  always_comb begin
    grant_s = 1'b0;
    grant_v = 1'b0;
    if (bus.s_req_valid && bus.v_req_valid) begin
`ifdef DMEM_ARB_RR_EN
      grant_s = (rr_prio == OWN_S);
      grant_v = (rr_prio == OWN_V);
`else
      grant_s = 1'b1;
`endif
    end else begin
      grant_s = bus.s_req_valid;
      grant_v = bus.v_req_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    beat_cnt_nx = beat_cnt;
    unique case (state)
      IDLE: begin
        if (grant_s) begin
          state_nx = SCAL;
        end else if (grant_v) begin
          state_nx    = VEC;
          beat_cnt_nx = '0;
        end
      end
      SCAL: begin
        if (s_hs) state_nx = IDLE;
      end
      VEC: begin
        if (v_hs) begin
          beat_cnt_nx = beat_cnt + 1'b1;
          // A burst that never raises last is cut off so the scalar side can get in.
          if (bus.v_req_last || beat_cnt_nx == CW'(MAX_BURST)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tag_in    = '0;
    sel_addr  = bus.v_req_addr;
    sel_wdata = bus.v_req_wdata;
    if (s_hs) begin
      tag_in.valid = 1'b1;
      tag_in.owner = OWN_S;
      tag_in.we    = bus.s_req_we;
      tag_in.fault = s_fault;
      sel_addr     = bus.s_req_addr;
      sel_wdata    = bus.s_req_wdata;
    end else if (v_hs) begin
      tag_in.valid = 1'b1;
      tag_in.owner = OWN_V;
      tag_in.we    = bus.v_req_we;
      tag_in.fault = v_fault;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag1        <= '0;
      tag2        <= '0;
      bus.m_en    <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
    end else begin
      tag1     <= tag_in;
      tag2     <= tag1;
      bus.m_en <= tag_in.valid & ~tag_in.fault;
      bus.m_we <= tag_in.valid & ~tag_in.fault & tag_in.we;
      if (tag_in.valid) begin
        bus.m_addr  <= sel_addr[IW+2:3];
        bus.m_wdata <= sel_wdata;
      end
    end
  end

  // Stage 2 lines up with the RAM's registered read data.
  always_comb begin
    rsp_data        = (tag2.valid && !tag2.we && !tag2.fault) ? bus.m_rdata : 64'd0;
    bus.s_rsp_valid = tag2.valid && (tag2.owner == OWN_S);
    bus.s_rsp_rdata = (tag2.owner == OWN_S) ? rsp_data : 64'd0;
    bus.s_rsp_fault = tag2.valid && (tag2.owner == OWN_S) && tag2.fault;
    bus.v_rsp_valid = tag2.valid && (tag2.owner == OWN_V);
    bus.v_rsp_rdata = (tag2.owner == OWN_V) ? rsp_data : 64'd0;
    bus.v_rsp_fault = tag2.valid && (tag2.owner == OWN_V) && tag2.fault;
  end

  assign busy = (state != IDLE) || tag1.valid || tag2.valid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized self-checking bench for dmem_arbiter
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int MEM_WORDS = 512;
  localparam int MAX_BURST = 8;
  localparam int IW        = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  dmem_arbiter_if #(.IW(IW)) bus ();

  dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .MAX_BURST(MAX_BURST)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [63:0] init_word(input int i);
    return (i == 8) ? 64'hDEAD_BEEF : {32'h5A5A_0000 | 32'(i), 32'(i) * 32'h9E37_79B9};
  endfunction

  logic [63:0] ram    [MEM_WORDS];
  bit          ram_wr [MEM_WORDS];
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) begin
        ram[bus.m_addr]    <= bus.m_wdata;
        ram_wr[bus.m_addr] <= 1'b1;
      end else begin
        bus.m_rdata <= ram_wr[bus.m_addr] ? ram[bus.m_addr] : init_word(int'(bus.m_addr));
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_n, act, exp);
    end
  endtask

  typedef struct {
    int          hs;
    logic        own;
    logic        we;
    logic        fault;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } beat_t;

  typedef struct {
    int          cyc;
    logic        own;
    logic [63:0] a;
    logic [63:0] d;
    logic        f;
  } ev_t;

  beat_t       q[$];
  logic [63:0] gold    [MEM_WORDS];
  bit          gold_wr [MEM_WORDS];
  int          grant = 0;
  int          beats = 0;
  int          prio  = 0;
  ev_t         hs_log[$];
  ev_t         m_log[$];
  ev_t         s_log[$];
  ev_t         v_log[$];

  function automatic beat_t mk_beat(input int c, input logic own, input logic we,
                                    input logic [63:0] a, input logic [63:0] d);
    beat_t b;
    b.hs    = c;
    b.own   = own;
    b.we    = we;
    b.addr  = a;
    b.wdata = d;
    b.rdata = 64'd0;
    b.fault = (a % 8 != 0) || (a / 8 >= 64'(MEM_WORDS));
    return b;
  endfunction

  task automatic model_step();
    int c = cyc_n;
    int w;
    int pick;
    bit hs_s;
    bit hs_v;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].hs == c - 1 && !q[i].fault) begin
        w = int'(q[i].addr / 8);
        if (q[i].we) begin
          gold[w]    = q[i].wdata;
          gold_wr[w] = 1'b1;
        end else begin
          q[i].rdata = gold_wr[w] ? gold[w] : init_word(w);
        end
      end
    end
    while (q.size() > 0 && q[0].hs < c - 1) void'(q.pop_front());
    hs_s = (grant == 1) && bus.s_req_valid;
    hs_v = (grant == 2) && bus.v_req_valid;
    if (hs_s) q.push_back(mk_beat(c, OWN_S, bus.s_req_we, bus.s_req_addr, bus.s_req_wdata));
    if (hs_v) q.push_back(mk_beat(c, OWN_V, bus.v_req_we, bus.v_req_addr, bus.v_req_wdata));
    if (grant == 1) begin
      if (hs_s) grant = 0;
    end else if (grant == 2) begin
      if (hs_v) begin
        beats++;
        if (bus.v_req_last || beats == MAX_BURST) grant = 0;
      end
    end else begin
      pick = 0;
      if (bus.s_req_valid && bus.v_req_valid) begin
`ifdef DMEM_ARB_RR_EN
        pick = (prio == 0) ? 1 : 2;
`else
        pick = 1;
`endif
      end else if (bus.s_req_valid) begin
        pick = 1;
      end else if (bus.v_req_valid) begin
        pick = 2;
      end
      if (pick != 0) begin
        grant = pick;
        beats = 0;
        prio  = (pick == 1) ? 1 : 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        grant = 0;
        beats = 0;
        prio  = 0;
        q.delete();
      end else begin
        model_step();
      end
    end
  end

  initial begin : compare
    int          c;
    bit          hc;
    bit          hr;
    bit          e_en;
    bit          e_sv;
    bit          e_vv;
    beat_t       cb;
    beat_t       rb;
    logic [63:0] e_rd;
    forever begin
      @(negedge clk);
      c = cyc_n;
      if (rst) begin
        chk("rst_s_ready", bus.s_req_ready, 0);
        chk("rst_v_ready", bus.v_req_ready, 0);
        chk("rst_m_en", bus.m_en, 0);
        chk("rst_m_we", bus.m_we, 0);
        chk("rst_m_addr", bus.m_addr, 0);
        chk("rst_m_wdata", bus.m_wdata, 0);
        chk("rst_s_rsp", {bus.s_rsp_valid, bus.s_rsp_fault}, 0);
        chk("rst_v_rsp", {bus.v_rsp_valid, bus.v_rsp_fault}, 0);
        chk("rst_s_rdata", bus.s_rsp_rdata, 0);
        chk("rst_v_rdata", bus.v_rsp_rdata, 0);
        chk("rst_busy", busy, 0);
      end else begin
        hc = 0;
        hr = 0;
        foreach (q[i]) begin
          if (q[i].hs == c - 1) begin hc = 1; cb = q[i]; end
          if (q[i].hs == c - 2) begin hr = 1; rb = q[i]; end
        end
        e_en = hc && !cb.fault;
        chk("s_req_ready", bus.s_req_ready, grant == 1);
        chk("v_req_ready", bus.v_req_ready, grant == 2);
        chk("m_en", bus.m_en, e_en);
        chk("m_we", bus.m_we, e_en && cb.we);
        if (e_en) chk("m_addr", bus.m_addr, cb.addr / 8);
        if (e_en && cb.we) chk("m_wdata", bus.m_wdata, cb.wdata);
        e_sv = hr && rb.own == OWN_S;
        e_vv = hr && rb.own == OWN_V;
        e_rd = (hr && !rb.we && !rb.fault) ? rb.rdata : 64'd0;
        chk("s_rsp_valid", bus.s_rsp_valid, e_sv);
        chk("s_rsp_rdata", bus.s_rsp_rdata, e_sv ? e_rd : 64'd0);
        chk("s_rsp_fault", bus.s_rsp_fault, e_sv && rb.fault);
        chk("v_rsp_valid", bus.v_rsp_valid, e_vv);
        chk("v_rsp_rdata", bus.v_rsp_rdata, e_vv ? e_rd : 64'd0);
        chk("v_rsp_fault", bus.v_rsp_fault, e_vv && rb.fault);
        chk("busy", busy, grant != 0 || q.size() > 0);
        if (bus.s_req_valid && bus.s_req_ready) hs_log.push_back('{c, OWN_S, bus.s_req_addr, 64'd0, 1'b0});
        if (bus.v_req_valid && bus.v_req_ready) hs_log.push_back('{c, OWN_V, bus.v_req_addr, 64'd0, 1'b0});
        if (bus.m_en) m_log.push_back('{c, 1'b0, 64'(bus.m_addr), bus.m_wdata, bus.m_we});
        if (bus.s_rsp_valid) s_log.push_back('{c, OWN_S, 64'd0, bus.s_rsp_rdata, bus.s_rsp_fault});
        if (bus.v_rsp_valid) v_log.push_back('{c, OWN_V, 64'd0, bus.v_rsp_rdata, bus.v_rsp_fault});
      end
    end
  end

  task automatic clear_logs();
    hs_log.delete();
    m_log.delete();
    s_log.delete();
    v_log.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic s_issue(input logic we, input logic [63:0] a, input logic [63:0] d);
    int n = 0;
    bit fire = 0;
    bus.s_req_valid = 1'b1;
    bus.s_req_we    = we;
    bus.s_req_addr  = a;
    bus.s_req_wdata = d;
    while (!fire && n < 100) begin
      @(negedge clk);
      fire = bus.s_req_ready;
      n++;
      @(posedge clk);
      #2;
    end
    bus.s_req_valid = 1'b0;
    if (!fire) chk("s_issue_timeout", 0, 1);
  endtask

  task automatic v_burst(input logic we, input logic [63:0] base, input int n, input bit use_last);
    int  t;
    bit  fire;
    for (int i = 0; i < n; i++) begin
      bus.v_req_valid = 1'b1;
      bus.v_req_we    = we;
      bus.v_req_addr  = base + 64'(8 * i);
      bus.v_req_wdata = 64'hC0DE_0000_0000_0000 | 64'(i);
      bus.v_req_last  = use_last && (i == n - 1);
      t    = 0;
      fire = 0;
      while (!fire && t < 100) begin
        @(negedge clk);
        fire = bus.v_req_ready;
        t++;
        @(posedge clk);
        #2;
      end
      if (!fire) chk("v_burst_timeout", 0, 1);
    end
    bus.v_req_valid = 1'b0;
    bus.v_req_last  = 1'b0;
  endtask

  function automatic logic [63:0] rnd_addr();
    int r = $urandom_range(0, 15);
    if (r == 0) return (64'($urandom_range(0, 40)) * 8) | 64'($urandom_range(1, 7));
    if (r == 1) return 64'($urandom_range(MEM_WORDS, MEM_WORDS + 80)) * 8;
    if (r == 2) return 64'h8000_0000_0000_0000 | (64'($urandom_range(0, 40)) * 8);
    return 64'($urandom_range(0, 40)) * 8;
  endfunction

  initial begin : watchdog
    #500_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int hs0;
    int n;
    bit fire;
    logic exp_own [4];
    bus.s_req_valid = 0; bus.s_req_we = 0; bus.s_req_addr = 0; bus.s_req_wdata = 0;
    bus.v_req_valid = 0; bus.v_req_we = 0; bus.v_req_addr = 0; bus.v_req_wdata = 0;
    bus.v_req_last  = 0;
    cycles(3);
    rst = 1'b0;
    cycles(2);
    chk("idle_busy", busy, 0);

    clear_logs();
    s_issue(0, 64'h40, 0);
    cycles(3);
    chk("t1_hs_count", hs_log.size(), 1);
    chk("t1_m_count", m_log.size(), 1);
    chk("t1_rsp_count", s_log.size(), 1);
    if (hs_log.size() == 1 && m_log.size() == 1 && s_log.size() == 1) begin
      hs0 = hs_log[0].cyc;
      chk("t1_m_en_cycle", m_log[0].cyc, hs0 + 1);
      chk("t1_m_addr", m_log[0].a, 8);
      chk("t1_rsp_cycle", s_log[0].cyc, hs0 + 2);
      chk("t1_rsp_rdata", s_log[0].d, 64'hDEAD_BEEF);
      chk("t1_rsp_fault", s_log[0].f, 0);
    end

    clear_logs();
    v_burst(1, 64'h100, 4, 1);
    cycles(3);
    chk("t2_wr_m_count", m_log.size(), 4);
    for (int i = 0; i < 4 && i < m_log.size(); i++) begin
      chk("t2_wr_m_cycle", m_log[i].cyc, m_log[0].cyc + i);
      chk("t2_wr_m_addr", m_log[i].a, 32 + i);
      chk("t2_wr_m_we", m_log[i].f, 1);
    end
    chk("t2_wr_idle", busy, 0);
    clear_logs();
    v_burst(0, 64'h100, 4, 1);
    cycles(3);
    chk("t2_rd_m_count", m_log.size(), 4);
    chk("t2_rd_rsp_count", v_log.size(), 4);
    for (int i = 1; i < m_log.size(); i++) chk("t2_rd_m_cycle", m_log[i].cyc, m_log[0].cyc + i);
    for (int i = 0; i < v_log.size(); i++) chk("t2_rd_data", v_log[i].d, 64'hC0DE_0000_0000_0000 | 64'(i));
    chk("t2_rd_idle", busy, 0);

    clear_logs();
    fork
      begin repeat (4) s_issue(0, 64'h48, 0); end
      begin repeat (4) v_burst(0, 64'h50, 1, 1); end
    join
    cycles(3);
`ifdef DMEM_ARB_RR_EN
    exp_own = '{OWN_S, OWN_V, OWN_S, OWN_V};
`else
    exp_own = '{OWN_S, OWN_S, OWN_S, OWN_S};
`endif
    chk("t3_hs_count", hs_log.size(), 8);
    for (int i = 0; i < 4 && i < hs_log.size(); i++) chk("t3_grant_owner", hs_log[i].own, exp_own[i]);

    clear_logs();
    fork
      begin v_burst(0, 64'h200, 10, 0); end
      begin cycles(3); s_issue(0, 64'h48, 0); end
    join
    chk("t4_hs_count", hs_log.size(), 11);
    for (int i = 0; i < 11 && i < hs_log.size(); i++)
      chk("t4_grant_owner", hs_log[i].own, (i == 8) ? OWN_S : OWN_V);
    v_burst(0, 64'h200, 1, 1);
    cycles(3);

    clear_logs();
    s_issue(0, 64'h1003, 0);
    cycles(3);
    s_issue(0, 64'h1000, 0);
    cycles(3);
    chk("t5_no_m_en", m_log.size(), 0);
    chk("t5_rsp_count", s_log.size(), 2);
    for (int i = 0; i < 2 && i < s_log.size() && i < hs_log.size(); i++) begin
      chk("t5_rsp_cycle", s_log[i].cyc, hs_log[i].cyc + 2);
      chk("t5_rsp_fault", s_log[i].f, 1);
      chk("t5_rsp_rdata", s_log[i].d, 0);
    end

    clear_logs();
    bus.v_req_valid = 1'b1;
    bus.v_req_we    = 1'b0;
    bus.v_req_addr  = 64'h300;
    bus.v_req_last  = 1'b1;
    fire = 0;
    n    = 0;
    while (!fire && n < 100) begin
      @(negedge clk);
      fire = bus.v_req_ready;
      n++;
      @(posedge clk);
      #2;
    end
    chk("t6_v_handshake", fire, 1);
    bus.v_req_valid = 1'b0;
    bus.v_req_last  = 1'b0;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(3);
    chk("t6_no_v_rsp", v_log.size(), 0);
    clear_logs();
    s_issue(0, 64'h40, 0);
    cycles(3);
    chk("t6_after_rsp_count", s_log.size(), 1);
    if (s_log.size() == 1 && hs_log.size() == 1) begin
      chk("t6_after_rsp_cycle", s_log[0].cyc, hs_log[0].cyc + 2);
      chk("t6_after_rsp_rdata", s_log[0].d, 64'hDEAD_BEEF);
    end

    fork
      begin
        repeat (150) begin
          cycles($urandom_range(1, 3));
          s_issue(1'($urandom_range(0, 1)), rnd_addr(), {$urandom, $urandom});
        end
      end
      begin
        repeat (60) begin
          cycles($urandom_range(0, 3));
          n = ($urandom_range(0, 3) == 0) ? 8 : $urandom_range(1, 6);
          v_burst(1'($urandom_range(0, 1)), rnd_addr(), n, (n == 8) ? 1'($urandom_range(0, 1)) : 1'b1);
        end
      end
    join
    cycles(5);
    chk("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
